// File: rtl/wb_stage_pkg.sv
// wb_stage shared types: default widths, FSM encoding, write-data selects.
// Imported by wb_stage_if, wb_fifo and wb_stage.
package wb_stage_pkg;

  localparam int WB_DW    = 8;
  localparam int WB_AW    = 4;
  localparam int WB_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_REQ = 2'd1,
    WRITE    = 2'd2
  } state_t;

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/wb_stage_if.sv
// EX -> WB result handshake (valid/ready) with the result payload.
// master = EX side, slave = writeback stage.
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW
) ();

  logic          valid;
  logic          ready;
  logic [AW-1:0] dest;
  logic [DW-1:0] result;
  logic          is_load;
  logic [DW-1:0] addr;

  modport master (
    output valid, dest, result, is_load, addr,
    input  ready
  );

  modport slave (
    input  valid, dest, result, is_load, addr,
    output ready
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO with wrap-bit pointers; exports per-slot valid bits
// and the top KW bits of every slot (the destination) for hazard masks.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int KW    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 head,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             vld,
  output logic [DEPTH-1:0][KW-1:0]     keys
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]               wptr;
  logic [PW:0]               rptr;
  logic [PW:0]               cnt;
  logic [DEPTH-1:0][W-1:0]   mem;

  logic do_push;
  logic do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) &&
                   (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[PW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop)
        rptr <= rptr + 1'b1;
    end
  end

  // a slot is live when its distance from the read pointer is < count
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    cnt = wptr - rptr;
    vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PW'(i) - rptr[PW-1:0];
      vld[i] = ({1'b0, off} < cnt);
    end
  end

  always_comb begin
    keys = '0;
    for (int i = 0; i < DEPTH; i++)
      keys[i] = mem[i][W-1 -: KW];
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: queues EX results, fetches load data, drives RF write port.
// Build option: WB_R0_DISCARD_EN suppresses writes to and hazards on R0.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW
) (
  input  logic               clk,
  input  logic               rst,
  wb_stage_if.slave          ex,
  output logic               mem_req,
  output logic [DW-1:0]      mem_addr,
  input  logic               mem_ack,
  input  logic [DW-1:0]      mem_rdata,
  output logic [AW-1:0]      regaddrc,
  output logic               RegCR,
  output logic [DW-1:0]      in,
  output logic [DW-1:0]      AorD,
  output logic               mux2CR,
  output logic [2**AW-1:0]   busy_mask
);

`ifdef WB_R0_DISCARD_EN
  localparam logic R0_DISCARD = 1'b1;
`else
  localparam logic R0_DISCARD = 1'b0;
`endif

  localparam int W = AW + 2*DW + 1;

  function automatic logic dest_we(input logic [AW-1:0] d);
    return !R0_DISCARD || (d != '0);
  endfunction

  state_t st, st_n;

  logic               mem_req_n;
  logic [DW-1:0]      mem_addr_n;
  logic [AW-1:0]      regaddrc_n;
  logic               RegCR_n;
  logic [DW-1:0]      in_n;
  logic [DW-1:0]      AorD_n;
  logic               mux2CR_n;
  logic [AW-1:0]      hdest, hdest_n;

  logic                      push, pop;
  logic                      full, empty;
  logic [W-1:0]              head;
  logic [DEPTH-1:0]          vld;
  logic [DEPTH-1:0][AW-1:0]  keys;

  logic [AW-1:0] h_dest;
  logic [DW-1:0] h_res;
  logic          h_ld;
  logic [DW-1:0] h_addr;

  assign ex.ready = !full;
  assign push     = ex.valid && !full;

  assign h_dest = head[W-1 -: AW];
  assign h_res  = head[W-AW-1 -: DW];
  assign h_ld   = head[DW];
  assign h_addr = head[DW-1:0];

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (W),
    .KW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({ex.dest, ex.result, ex.is_load, ex.addr}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .vld   (vld),
    .keys  (keys)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      regaddrc <= '0;
      RegCR    <= 1'b0;
      in       <= '0;
      AorD     <= '0;
      mux2CR   <= SEL_ALU;
      hdest    <= '0;
    end else begin
      st       <= st_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
      regaddrc <= regaddrc_n;
      RegCR    <= RegCR_n;
      in       <= in_n;
      AorD     <= AorD_n;
      mux2CR   <= mux2CR_n;
      hdest    <= hdest_n;
    end
  end

  // WRITE dispatches the next head directly so ALU writes stream 1/clk
  always_comb begin
    st_n       = st;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    regaddrc_n = regaddrc;
    RegCR_n    = 1'b0;
    in_n       = in;
    AorD_n     = AorD;
    mux2CR_n   = mux2CR;
    hdest_n    = hdest;
    pop        = 1'b0;
    unique case (st)
      IDLE, WRITE: begin
        st_n = IDLE;
        if (!empty) begin
          pop     = 1'b1;
          hdest_n = h_dest;
          if (h_ld) begin
            st_n       = LOAD_REQ;
            mem_req_n  = 1'b1;
            mem_addr_n = h_addr;
          end else begin
            st_n       = WRITE;
            RegCR_n    = dest_we(h_dest);
            regaddrc_n = h_dest;
            in_n       = h_res;
            mux2CR_n   = SEL_ALU;
          end
        end
      end
      LOAD_REQ: begin
        if (mem_ack) begin
          st_n       = WRITE;
          mem_req_n  = 1'b0;
          AorD_n     = mem_rdata;
          mux2CR_n   = SEL_MEM;
          RegCR_n    = dest_we(hdest);
          regaddrc_n = hdest;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i])
        busy_mask[keys[i]] = 1'b1;
    if (st != IDLE)
      busy_mask[hdest] = 1'b1;
    if (R0_DISCARD)
      busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: scoreboard of expected RF writes
// checked by a negedge monitor, plus inline checks of handshake/mask.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

`ifdef WB_R0_DISCARD_EN
  localparam logic R0DISC = 1'b1;
`else
  localparam logic R0DISC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_req;
  logic [DW-1:0]    mem_addr;
  logic             mem_ack;
  logic [DW-1:0]    mem_rdata;
  logic [AW-1:0]    regaddrc;
  logic             RegCR;
  logic [DW-1:0]    in_d;
  logic [DW-1:0]    AorD;
  logic             mux2CR;
  logic [2**AW-1:0] busy_mask;

  always #5 clk = ~clk;

  wb_stage_if #(.AW(AW), .DW(DW)) ex ();

  wb_stage #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ex        (ex),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .regaddrc  (regaddrc),
    .RegCR     (RegCR),
    .in        (in_d),
    .AorD      (AorD),
    .mux2CR    (mux2CR),
    .busy_mask (busy_mask)
  );

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic          sel;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // each RegCR strobe must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (RegCR === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_unexpected: got dest %0h expected none",
                 regaddrc);
      end else begin
        e = sb.pop_front();
        chk("wr_dest", 32'(regaddrc), 32'(e.dest));
        chk("wr_data", 32'(mux2CR ? AorD : in_d), 32'(e.data));
        chk("wr_sel", 32'(mux2CR), 32'(e.sel));
      end
    end
  end

  task automatic push(input logic [AW-1:0] d,
                      input logic [DW-1:0] r,
                      input logic          ld,
                      input logic [DW-1:0] a,
                      input logic [DW-1:0] xd);
    int n;
    n = 0;
    ex.valid   = 1'b1;
    ex.dest    = d;
    ex.result  = r;
    ex.is_load = ld;
    ex.addr    = a;
    if (!(R0DISC && d == '0))
      sb.push_back('{d, xd, ld});
    while (ex.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: got ready %b expected 1", ex.ready);
    end
    @(posedge clk);
    #1;
    ex.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    ex.valid   = 1'b0;
    ex.dest    = '0;
    ex.result  = '0;
    ex.is_load = 1'b0;
    ex.addr    = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_regcr", 32'(RegCR), 0);
    chk("rst_regaddrc", 32'(regaddrc), 0);
    chk("rst_in", 32'(in_d), 0);
    chk("rst_aord", 32'(AorD), 0);
    chk("rst_mux", 32'(mux2CR), 0);
    chk("rst_memreq", 32'(mem_req), 0);
    chk("rst_memaddr", 32'(mem_addr), 0);
    chk("rst_busy", 32'(busy_mask), 0);
    chk("rst_ready", 32'(ex.ready), 1);

    // single ALU write
    push(4'd11, 8'd80, 1'b0, 8'h00, 8'd80);
    @(negedge clk);
    chk("t1_busy_q", 32'(busy_mask), 32'h0800);
    chk("t1_early", 32'(RegCR), 0);
    @(negedge clk);
    chk("t1_pulse", 32'(RegCR), 1);
    @(negedge clk);
    chk("t1_busy_clr", 32'(busy_mask), 0);
    chk("t1_single", 32'(RegCR), 0);

    // load stalls the queue until four ALU entries fill it
    push(4'd9, 8'd0, 1'b1, 8'h10, 8'h77);
    push(4'd1, 8'd10, 1'b0, 8'h00, 8'd10);
    push(4'd2, 8'd20, 1'b0, 8'h00, 8'd20);
    push(4'd3, 8'd30, 1'b0, 8'h00, 8'd30);
    push(4'd4, 8'd40, 1'b0, 8'h00, 8'd40);
    @(negedge clk);
    chk("t2_full", 32'(ex.ready), 0);
    chk("t2_busy", 32'(busy_mask), 32'h021E);
    chk("t2_req", 32'(mem_req), 1);
    chk("t2_addr", 32'(mem_addr), 32'h10);
    fork
      push(4'd12, 8'd99, 1'b0, 8'h00, 8'd99);
      begin
        mem_rdata = 8'h77;
        mem_ack   = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("t2_train", 32'(RegCR), 1);
        end
      end
    join
    repeat (4) @(negedge clk);
    chk("t2_drained", 32'(busy_mask), 0);

    // load with ack on the third request cycle
    push(4'd5, 8'd0, 1'b1, 8'h3C, 8'd90);
    @(negedge clk);
    chk("t3_noreq", 32'(mem_req), 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t3_req", 32'(mem_req), 1);
      chk("t3_addr", 32'(mem_addr), 32'h3C);
      if (k == 3) begin
        mem_rdata = 8'd90;
        mem_ack   = 1'b1;
      end
    end
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    chk("t3_pulse", 32'(RegCR), 1);
    chk("t3_req_drop", 32'(mem_req), 0);

    // load blocks younger ALU writes
    push(4'd5, 8'd0, 1'b1, 8'h20, 8'h11);
    push(4'd6, 8'h66, 1'b0, 8'h00, 8'h66);
    push(4'd7, 8'h77, 1'b0, 8'h00, 8'h77);
    @(negedge clk);
    chk("t4_busy", 32'(busy_mask), 32'h00E0);
    chk("t4_nowrite", 32'(RegCR), 0);
    mem_rdata = 8'h11;
    mem_ack   = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_busy_clr", 32'(busy_mask), 0);

    // reset in the middle of a load
    push(4'd8, 8'd0, 1'b1, 8'h44, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("t5_req", 32'(mem_req), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    mem_rdata = 8'hAB;
    mem_ack   = 1'b1;
    @(negedge clk);
    chk("t5_memreq", 32'(mem_req), 0);
    chk("t5_memaddr", 32'(mem_addr), 0);
    chk("t5_regcr", 32'(RegCR), 0);
    chk("t5_aord", 32'(AorD), 0);
    chk("t5_busy", 32'(busy_mask), 0);
    chk("t5_ready", 32'(ex.ready), 1);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t5_nowrite", 32'(RegCR), 0);
    end

    // write to R0
    push(4'd0, 8'd55, 1'b0, 8'h00, 8'd55);
    @(negedge clk);
    chk("t6_busy", 32'(busy_mask), R0DISC ? 0 : 1);
    @(negedge clk);
    chk("t6_we", 32'(RegCR), R0DISC ? 0 : 1);
    repeat (2) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 8-bit RISC pipeline; the writer side of the ID-stage register file.
- Accepts completed results from EX through a valid/ready handshake and buffers them in a small FIFO.
- ALU results are written directly. Loads first fetch data memory, then write.
- Drives the register-file write port: regaddrc, RegCR, in, AorD, mux2CR.
- Exports a pending-write mask for hazard detection.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- DW, 8, data width.
- AW, 4, register address width (2**AW registers).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX offers a result.
- ex_ready  out  1  FIFO can accept; equals !full.
- ex_dest  in  AW  destination register.
- ex_result  in  DW  ALU result (ignored when ex_is_load).
- ex_is_load  in  1  entry is a load.
- ex_addr  in  DW  load address.
- mem_req  out  1  data-memory read request.
- mem_addr  out  DW  read address.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  DW  read data.
- regaddrc  out  AW  register-file write address.
- RegCR  out  1  register-file write enable (one-cycle strobe per write).
- in  out  DW  ALU write data.
- AorD  out  DW  load write data.
- mux2CR  out  1  write-data select: 0 = in, 1 = AorD.
- busy_mask  out  2**AW  bit r set while a write to r is queued or in flight.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - FIFO emptied; state IDLE.
  - mem_req, mem_addr, regaddrc, RegCR, in, AorD, mux2CR all 0; busy_mask 0.
  - Reset overrides every other event in that cycle.
- Push: ex_valid && ex_ready at an edge writes {dest, result, is_load, addr}.
  - ex_ready is !full only; a pop in the same cycle does not raise it.
  - ex_valid while full is ignored, and EX holds the entry.
- FSM states: IDLE, LOAD_REQ, WRITE. All outputs are registered.
- IDLE:
  - FIFO empty → stay IDLE.
  - Head is ALU → WRITE: RegCR=1, regaddrc=dest, in=result, mux2CR=0; pop head.
  - Head is load → LOAD_REQ: mem_req=1, mem_addr=addr; pop head; dest held internally.
- LOAD_REQ:
  - Hold mem_req/mem_addr until mem_ack is sampled high.
  - mem_ack may arrive in the first LOAD_REQ cycle.
  - On ack: AorD=mem_rdata, mux2CR=1, RegCR=1, regaddrc=held dest, mem_req=0 → WRITE.
- WRITE:
  - RegCR is high for exactly this cycle; the register file captures at its end.
  - Next state follows the IDLE rules without an intervening IDLE cycle (back-to-back ALU writes: 1 per clock).
  - Otherwise → IDLE with RegCR=0.
- Latency:
  - ALU entry pushed at edge N into an empty, idle stage: RegCR high in the cycle after edge N+1.
  - Load: RegCR high in the cycle after the edge sampling mem_ack.
- in and AorD hold their last values when not written; mux2CR is meaningful only while RegCR=1.
- busy_mask: combinational OR of one-hot(dest) over valid FIFO entries, plus the held dest in LOAD_REQ and WRITE.
  - A register is cleared from the mask the cycle after its WRITE, unless it is still queued.
- Ordering: writes occur strictly in push order. A load blocks younger ALU writes.
- FIFO wrap-around: pointers are AW-independent, log2(DEPTH)+1 bits; full/empty come from the MSB compare.
- Reset mid-load: mem_req drops at the reset edge; a later mem_ack is ignored in IDLE.

Optional Feature:
- Macro: WB_R0_DISCARD_EN.
- Defined: entries with dest==0 are still accepted and still occupy the FIFO and memory cycle.
  - RegCR stays 0 for their write cycle, so R0 is never written.
  - R0 is never set in busy_mask.
- Undefined: R0 is treated as a normal register.

Decomposition:
- Shared package/header: DW, AW defaults; FSM state encodings (IDLE=0, LOAD_REQ=1, WRITE=2); mux2CR select constants (SEL_ALU=0, SEL_MEM=1).
- One sub-module: wb_fifo (parameterised sync FIFO with push/pop/full/empty and an entry-valid vector for busy_mask).

Test Plan:
- Reset then push ALU {dest=11, result=80} → one cycle later RegCR=1, regaddrc=11, in=80, mux2CR=0; busy_mask[11] clears afterwards.
- Four consecutive ALU pushes (dest 1..4, results 10..40) → four consecutive RegCR pulses in order; ex_ready low when DEPTH=4 entries are queued.
- Load {dest=5, addr=0x3C}, mem_ack after 3 cycles with rdata=90 → mem_req/mem_addr=0x3C held 3 cycles; then RegCR=1, regaddrc=5, AorD=90, mux2CR=1.
- Load followed by ALU {dest=6, 7} with mem_ack after 2 cycles → dest 6 write only after the dest 5 write; busy_mask has bits 5 and 6 set while waiting.
- Assert rst during LOAD_REQ, then mem_ack → outputs zero, no RegCR, FIFO empty, ex_ready=1.
- With WB_R0_DISCARD_EN, push ALU {dest=0, result=55} → no RegCR pulse, busy_mask stays 0; without the macro → RegCR pulse to register 0.
